ula_serial_16: RTL



---
 rtl/ula_serial_16.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ula_serial_16.sv
// Serial sequencer that drives one 74181-style 4-bit ALU a nibble per clock,
// least significant first, rippling carry between nibbles into a wide result.

module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       a_eq_b
);
  logic [3:0] e, d, h, g, p;
  logic       carry;

  // c_in/c_out are active-low; internally the ripple carry is active-high.
  always_comb begin
    e     = ~((a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}}));
    d     = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
    h     = e ^ d;
    g     = ~e;
    p     = ~d;
    f     = '0;
    carry = ~c_in;
    for (int i = 0; i < 4; i++) begin
      f[i]  = ~h[i] ^ (~m & ~carry);
      carry = g[i] | (p[i] & carry);
    end
    c_out  = ~carry;
    a_eq_b = &f;
  end
endmodule

module ula_serial_16 #(
  parameter int N_NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*N_NIB-1:0] op_a,
  input  logic [4*N_NIB-1:0] op_b,
  input  logic [3:0]         op_s,
  input  logic               op_m,
  input  logic               op_cin,
  output logic               busy,
  output logic               done,
  output logic [4*N_NIB-1:0] result,
  output logic               cout,
  output logic               eq
);
  localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NIB - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [N_NIB-1:0][3:0]  a_q, b_q, res_q;
  logic [3:0]             s_q;
  logic                   m_q;
  logic                   carry_q;
  logic                   eq_acc;
  logic [IDX_W-1:0]       idx;
  logic                   accept;
  logic                   last_nib;
  logic [3:0]             alu_f;
  logic                   alu_cout;
  logic                   alu_eq;

  ula_74181 u_alu (
    .a      (a_q[idx]),
    .b      (b_q[idx]),
    .s      (s_q),
    .m      (m_q),
    .c_in   (carry_q),
    .f      (alu_f),
    .c_out  (alu_cout),
    .a_eq_b (alu_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_nib  = (idx == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_nib) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state == RUN);
  assign result = res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      eq_acc  <= 1'b0;
      idx     <= '0;
      res_q   <= '0;
      cout    <= 1'b0;
      eq      <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= busy && last_nib;
      if (accept) begin
        a_q     <= op_a;
        b_q     <= op_b;
        s_q     <= op_s;
        m_q     <= op_m;
        carry_q <= op_cin;
        eq_acc  <= 1'b1;
        idx     <= '0;
      end else if (busy) begin
        res_q[idx] <= alu_f;
        carry_q    <= alu_cout;
        eq_acc     <= eq_acc & alu_eq;
        if (last_nib) begin
          cout <= alu_cout;
          eq   <= eq_acc & alu_eq;
          idx  <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule
